vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Generates the pixel-clock enable, raster counters and sync/blank signals for the 640x480@60 Hz display. Its `col`/`row` outputs feed every downstream range and offset check that decides what is drawn at the current pixel, such as arena walls, light-cycle trails and the score area. Its `hsync_n`/`vsync_n` go to the VGA pins. It sits at the head of the video pipeline: its only inputs are the system clock and reset.

## Interface
Parameters:
- `H_VISIBLE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch (pixels)
- `H_SYNC`, 96: horizontal sync width (pixels)
- `H_BP`, 48: horizontal back porch (pixels)
- `V_VISIBLE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch (lines)
- `V_SYNC`, 2: vertical sync width (lines)
- `V_BP`, 33: vertical back porch (lines)
- `CLK_DIV`, 2: system clocks per pixel, ≥1 (50 MHz → 25 MHz)
- `WIDTH`, 10: width of `col`/`row`

Ports (one clock; reset is synchronous and active-high):
- `clock` input 1: system clock
- `reset` input 1: synchronous, active-high
- `pixel_en` output 1: last system cycle of the current pixel; counters advance at the following edge
- `col` output WIDTH: horizontal count, 0..H_TOTAL-1
- `row` output WIDTH: vertical count, 0..V_TOTAL-1
- `hsync_n` output 1: active-low horizontal sync
- `vsync_n` output 1: active-low vertical sync
- `blank` output 1: high outside the visible region
- `line_start` output 1: one-cycle pulse, first pixel of each line
- `frame_start` output 1: one-cycle pulse, first pixel of each frame

## Operation
- H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525).
- Elaboration-time `$error` if CLK_DIV < 1 or if 2^WIDTH < max(H_TOTAL, V_TOTAL).
- Divider register `div`, 0..CLK_DIV-1, increments every cycle and wraps. `pixel_en` = (div == CLK_DIV-1) & ~reset. With CLK_DIV=1, `pixel_en` is constant 1 outside reset.
- `col`/`row` are the counter registers themselves. They change only at an edge where `pixel_en` was 1.
- On `pixel_en`:
  - If col < H_TOTAL-1: col+1.
  - Otherwise col → 0 and row advances: row+1 if row < V_TOTAL-1, otherwise row → 0.
- Horizontal phases by col: VISIBLE [0, H_VISIBLE-1], FP, SYNC [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1], BP. Vertical phases by row are the same with the V_ parameters.
- Decoded outputs are combinational from the counter registers, so they are aligned with `col`/`row` with no offset:
  - `hsync_n` = 0 iff col is in the horizontal SYNC phase.
  - `vsync_n` = 0 iff row is in the vertical SYNC phase. It applies for whole lines, including their porch columns.
  - `blank` = (col ≥ H_VISIBLE) | (row ≥ V_VISIBLE).
  - `line_start` = pixel_en & (col == 0).
  - `frame_start` = pixel_en & (col == 0) & (row == 0).
- Downstream stages sample `col`/`row`/`blank` in the `pixel_en` cycle.

## Timing
- Reset values, held every cycle while reset is high: div=0, col=0, row=0, pixel_en=0, hsync_n=1, vsync_n=1, blank=0, line_start=0, frame_start=0.
- First cycle after reset deasserts: div=0. `pixel_en` first rises CLK_DIV-1 cycles later, coinciding with `frame_start` for pixel (0,0).
- Each pixel is held CLK_DIV cycles. Line period = H_TOTAL·CLK_DIV = 1600 clocks. Frame period = 840000 clocks.
- Wrap at (H_TOTAL-1, V_TOTAL-1) with pixel_en: the next pixel is (0,0), and `frame_start` fires in its pixel_en cycle.
- Reset mid-frame: reset overrides `pixel_en` and wrap logic. The next edge yields (0,0) and div=0, with no partial sync pulse.
- `line_start` and `frame_start` are never high for more than one consecutive cycle when CLK_DIV > 1.

## Test plan
- Reset: hold reset 5 cycles, check all reset values each cycle. Release; with CLK_DIV=2, `pixel_en` = 0,1,0,1…, and the first `pixel_en` cycle has `frame_start`=1, col=0, row=0.
- Line timing (defaults):
  - `hsync_n` low exactly for col 656..751 (192 clocks).
  - `blank` high for col 640..799 on row 0.
  - `line_start` spacing 1600 clocks.
- Frame timing:
  - `vsync_n` low exactly for rows 490..491 (3200 clocks).
  - `blank` high for all of rows 480..524.
  - `frame_start` spacing 840000 clocks, and exactly 525 `line_start` pulses per frame.
- Wrap: at col=799, row=524 with pixel_en, the next pixel is col=0, row=0, and `frame_start` pulses exactly once in that pixel.
- Mid-frame reset: assert reset 1 cycle at col=300, row=200, div=1. The next cycle shows col=0, row=0, div=0; the following cycle has `pixel_en`=1 with `frame_start`=1.
- Reduced parameters (CLK_DIV=1, H 4/1/2/1, V 3/1/1/1, WIDTH 4): run 3 full frames. Compare every cycle against a reference model for col, row, hsync_n, vsync_n, blank and both pulses.

Source files
------------

// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// vga_timing_gen: pixel-clock enable, raster counters and decoded sync/blank
// signals for a VGA raster (640x480@60 Hz with the default parameters).
// col/row are the counter registers themselves. Every decoded output is
// combinational from them, so they line up with col/row with no offset.
// Downstream stages sample col/row/blank in the pixel_en cycle.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int CLK_DIV   = 2,
    parameter int WIDTH     = 10
) (
    input  logic             clock,
    input  logic             reset,
    output logic             pixel_en,
    output logic [WIDTH-1:0] col,
    output logic [WIDTH-1:0] row,
    output logic             hsync_n,
    output logic             vsync_n,
    output logic             blank,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;
    localparam int DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [WIDTH-1:0] H_LAST   = WIDTH'(H_TOTAL - 1);
    localparam logic [WIDTH-1:0] V_LAST   = WIDTH'(V_TOTAL - 1);
    localparam logic [WIDTH-1:0] H_VIS    = WIDTH'(H_VISIBLE);
    localparam logic [WIDTH-1:0] V_VIS    = WIDTH'(V_VISIBLE);
    localparam logic [WIDTH-1:0] HS_FIRST = WIDTH'(H_VISIBLE + H_FP);
    localparam logic [WIDTH-1:0] HS_LAST  = WIDTH'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [WIDTH-1:0] VS_FIRST = WIDTH'(V_VISIBLE + V_FP);
    localparam logic [WIDTH-1:0] VS_LAST  = WIDTH'(V_VISIBLE + V_FP + V_SYNC - 1);

    // Parameter sanity: a zero divider or counters too narrow for the raster
    // would silently produce a broken picture, so stop at elaboration.
    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be >= 1");
    end
    if ((longint'(1) << WIDTH) < longint'(MAX_TOTAL)) begin : g_bad_width
        $error("vga_timing_gen: WIDTH too small for H_TOTAL/V_TOTAL");
    end

    logic [DIV_W-1:0] div_q, div_d;
    logic [WIDTH-1:0] col_q, col_d;
    logic [WIDTH-1:0] row_q, row_d;
    logic             h_sync_phase;
    logic             v_sync_phase;

    // Reset overrides the enable so no pixel advance can leak through it.
    assign pixel_en = (div_q == DIV_LAST) && !reset;

    // Next divider value: count 0..CLK_DIV-1 and wrap.
    always_comb begin
        div_d = div_q + DIV_W'(1);
        if (div_q == DIV_LAST) begin
            div_d = '0;
        end
    end

    // Next raster position: advance one pixel on pixel_en, wrapping the line
    // and then the frame.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (pixel_en) begin
            if (col_q != H_LAST) begin
                col_d = col_q + WIDTH'(1);
            end else begin
                col_d = '0;
                if (row_q != V_LAST) begin
                    row_d = row_q + WIDTH'(1);
                end else begin
                    row_d = '0;
                end
            end
        end
    end

    // Divider and raster counter registers with synchronous reset to (0,0).
    always_ff @(posedge clock) begin
        if (reset) begin
            div_q <= '0;
            col_q <= '0;
            row_q <= '0;
        end else begin
            div_q <= div_d;
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Phase decode straight from the counters; vsync covers whole lines,
    // porch columns included.
    always_comb begin
        h_sync_phase = (col_q >= HS_FIRST) && (col_q <= HS_LAST);
        v_sync_phase = (row_q >= VS_FIRST) && (row_q <= VS_LAST);
    end

    assign col         = col_q;
    assign row         = row_q;
    assign hsync_n     = !h_sync_phase;
    assign vsync_n     = !v_sync_phase;
    assign blank       = (col_q >= H_VIS) || (row_q >= V_VIS);
    assign line_start  = pixel_en && (col_q == '0);
    assign frame_start = pixel_en && (col_q == '0) && (row_q == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
// Bench for vga_timing_gen. Three instances run side by side:
//   a: default 640x480 timing, CLK_DIV=2 (reset, release and line timing)
//   b: mid-size raster 56x37, CLK_DIV=2 (frame timing, wrap, mid-frame reset)
//   c: tiny raster 8x6, CLK_DIV=1, WIDTH=4 (many full frames)
// The reference model derives every output from the number of clock edges
// since the last reset edge, using plain division and modulo.
module tb_vga_timing_gen;

    logic clk;
    logic rst_a, rst_b, rst_c;

    logic       pe_a, hs_a, vs_a, bl_a, ls_a, fs_a;
    logic [9:0] col_a, row_a;
    logic       pe_b, hs_b, vs_b, bl_b, ls_b, fs_b;
    logic [5:0] col_b, row_b;
    logic       pe_c, hs_c, vs_c, bl_c, ls_c, fs_c;
    logic [3:0] col_c, row_c;

    int n_checks = 0;
    int n_fail   = 0;

    vga_timing_gen dut_a (
        .clock(clk), .reset(rst_a), .pixel_en(pe_a), .col(col_a), .row(row_a),
        .hsync_n(hs_a), .vsync_n(vs_a), .blank(bl_a),
        .line_start(ls_a), .frame_start(fs_a)
    );

    vga_timing_gen #(
        .H_VISIBLE(40), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_VISIBLE(30), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .CLK_DIV(2), .WIDTH(6)
    ) dut_b (
        .clock(clk), .reset(rst_b), .pixel_en(pe_b), .col(col_b), .row(row_b),
        .hsync_n(hs_b), .vsync_n(vs_b), .blank(bl_b),
        .line_start(ls_b), .frame_start(fs_b)
    );

    vga_timing_gen #(
        .H_VISIBLE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_VISIBLE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(1), .WIDTH(4)
    ) dut_c (
        .clock(clk), .reset(rst_c), .pixel_en(pe_c), .col(col_c), .row(row_c),
        .hsync_n(hs_c), .vsync_n(vs_c), .blank(bl_c),
        .line_start(ls_c), .frame_start(fs_c)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- model time per instance ----------------
    // t_x = clock edges since the last edge that sampled reset high.
    int t_a = 0, t_b = 0, t_c = 0;
    bit ok_a = 0, ok_b = 0, ok_c = 0;

    always @(posedge clk) begin
        t_a  <= rst_a ? 0 : t_a + 1;
        t_b  <= rst_b ? 0 : t_b + 1;
        t_c  <= rst_c ? 0 : t_c + 1;
        ok_a <= ok_a | rst_a;
        ok_b <= ok_b | rst_b;
        ok_c <= ok_c | rst_c;
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_inst(
        input string tag, input int t, input int d,
        input int hv, input int hf, input int hs, input int hb,
        input int vv, input int vf, input int vs, input int vb,
        input bit rst,
        input int a_col, input int a_row,
        input bit a_pe, input bit a_hs, input bit a_vs, input bit a_bl,
        input bit a_ls, input bit a_fs);
        int ht, vt, p, e_col, e_row;
        bit e_pe, e_hs, e_vs, e_bl, e_ls, e_fs;
        ht    = hv + hf + hs + hb;
        vt    = vv + vf + vs + vb;
        p     = t / d;
        e_col = p % ht;
        e_row = (p / ht) % vt;
        e_pe  = !rst && ((t % d) == d - 1);
        e_hs  = !((e_col >= hv + hf) && (e_col < hv + hf + hs));
        e_vs  = !((e_row >= vv + vf) && (e_row < vv + vf + vs));
        e_bl  = (e_col >= hv) || (e_row >= vv);
        e_ls  = e_pe && (e_col == 0);
        e_fs  = e_ls && (e_row == 0);
        check({tag, "_col"},         a_col,     e_col);
        check({tag, "_row"},         a_row,     e_row);
        check({tag, "_pixel_en"},    int'(a_pe), int'(e_pe));
        check({tag, "_hsync_n"},     int'(a_hs), int'(e_hs));
        check({tag, "_vsync_n"},     int'(a_vs), int'(e_vs));
        check({tag, "_blank"},       int'(a_bl), int'(e_bl));
        check({tag, "_line_start"},  int'(a_ls), int'(e_ls));
        check({tag, "_frame_start"}, int'(a_fs), int'(e_fs));
    endtask

    // ---------------- compare process ----------------
    // Per-cycle model comparison plus interval measurements against
    // hand-computed literals.
    int a_gap = 0, a_hs_lo = 0, a_bl0 = 0;
    bit a_seen = 0;
    int b_gap = 0, b_vs_lo = 0, b_fs_pix = 0;
    bit b_seen = 0, b_wrap = 0;
    int c_gap = 0, c_vs_lo = 0, c_ls_cnt = 0;
    bit c_seen = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (ok_a) check_inst("a", t_a, 2, 640, 16, 96, 48, 480, 10, 2, 33, rst_a,
                                 int'(col_a), int'(row_a), pe_a, hs_a, vs_a, bl_a, ls_a, fs_a);
            if (ok_b) check_inst("b", t_b, 2, 40, 4, 8, 4, 30, 2, 2, 3, rst_b,
                                 int'(col_b), int'(row_b), pe_b, hs_b, vs_b, bl_b, ls_b, fs_b);
            if (ok_c) check_inst("c", t_c, 1, 4, 1, 2, 1, 3, 1, 1, 1, rst_c,
                                 int'(col_c), int'(row_c), pe_c, hs_c, vs_c, bl_c, ls_c, fs_c);

            // default raster: line period, hsync width, row-0 blanking
            if (ok_a && !rst_a) begin
                a_gap++;
                if (!hs_a) a_hs_lo++;
                if (bl_a && row_a == 10'd0) a_bl0++;
                if (ls_a) begin
                    if (a_seen) begin
                        check("a_line_start_gap", a_gap, 1600);
                        check("a_hsync_low_clocks", a_hs_lo, 192);
                        if (row_a == 10'd1) check("a_row0_blank_clocks", a_bl0, 320);
                    end
                    a_seen  = 1;
                    a_gap   = 0;
                    a_hs_lo = 0;
                end
            end

            // mid-size raster: frame period, vsync width, wrap to (0,0)
            if (!ok_b || rst_b) begin
                b_seen = 0;
                b_wrap = 0;
            end else begin
                b_gap++;
                if (!vs_b) b_vs_lo++;
                if (fs_b) begin
                    if (b_seen) begin
                        check("b_frame_start_gap", b_gap, 4144);
                        check("b_vsync_low_clocks", b_vs_lo, 224);
                    end
                    b_seen  = 1;
                    b_gap   = 0;
                    b_vs_lo = 0;
                end
                if (b_wrap) begin
                    if (fs_b) b_fs_pix++;
                    if (pe_b) begin
                        check("b_wrap_col", int'(col_b), 0);
                        check("b_wrap_row", int'(row_b), 0);
                        check("b_wrap_fs_count", b_fs_pix, 1);
                        b_wrap = 0;
                    end
                end
                if (pe_b && col_b == 6'd55 && row_b == 6'd36) begin
                    b_wrap   = 1;
                    b_fs_pix = 0;
                end
            end

            // tiny raster: frame period, lines per frame, vsync width
            if (ok_c && !rst_c) begin
                c_gap++;
                if (!vs_c) c_vs_lo++;
                if (fs_c) begin
                    if (c_seen) begin
                        check("c_frame_start_gap", c_gap, 48);
                        check("c_lines_per_frame", c_ls_cnt, 6);
                        check("c_vsync_low_clocks", c_vs_lo, 8);
                    end
                    c_seen   = 1;
                    c_gap    = 0;
                    c_vs_lo  = 0;
                    c_ls_cnt = 0;
                end
                if (ls_c) c_ls_cnt++;
            end
        end
    end

    // ---------------- driver / directed sequence ----------------
    initial begin
        bit found;
        rst_a = 1'b1;
        rst_b = 1'b1;
        rst_c = 1'b1;

        // reset held: every output at its reset value each cycle
        repeat (5) begin
            @(negedge clk);
            check("rst_pixel_en",    int'(pe_a), 0);
            check("rst_col",         int'(col_a), 0);
            check("rst_row",         int'(row_a), 0);
            check("rst_hsync_n",     int'(hs_a), 1);
            check("rst_vsync_n",     int'(vs_a), 1);
            check("rst_blank",       int'(bl_a), 0);
            check("rst_line_start",  int'(ls_a), 0);
            check("rst_frame_start", int'(fs_a), 0);
        end

        @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;

        // release: pixel_en 0,1,0,1 and frame_start on the first enable
        @(negedge clk);
        check("rel0_pixel_en", int'(pe_a), 0);
        @(negedge clk);
        check("rel1_pixel_en",    int'(pe_a), 1);
        check("rel1_frame_start", int'(fs_a), 1);
        check("rel1_col",         int'(col_a), 0);
        check("rel1_row",         int'(row_a), 0);
        @(negedge clk);
        check("rel2_pixel_en", int'(pe_a), 0);
        @(negedge clk);
        check("rel3_pixel_en",    int'(pe_a), 1);
        check("rel3_col",         int'(col_a), 1);
        check("rel3_frame_start", int'(fs_a), 0);

        repeat (5000) @(negedge clk);

        // mid-frame reset on instance b: find (30,20) in its div=0 cycle
        found = 0;
        for (int i = 0; i < 6000 && !found; i++) begin
            @(negedge clk);
            if (col_b == 6'd30 && row_b == 6'd20 && !pe_b) found = 1;
        end
        check("b_reset_target_found", int'(found), 1);
        if (found) begin
            @(posedge clk);
            #1;
            rst_b = 1'b1;
            @(negedge clk);
            check("mid_rst_pixel_en", int'(pe_b), 0);
            check("mid_rst_col",      int'(col_b), 30);
            @(posedge clk);
            #1;
            rst_b = 1'b0;
            @(negedge clk);
            check("mid_after_col",      int'(col_b), 0);
            check("mid_after_row",      int'(row_b), 0);
            check("mid_after_pixel_en", int'(pe_b), 0);
            @(negedge clk);
            check("mid_next_pixel_en",    int'(pe_b), 1);
            check("mid_next_frame_start", int'(fs_b), 1);
        end

        // at least one more full frame of b after its reset
        repeat (4400) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
